// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state and the memory arbiter's FSM, class and grant types.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_class_t;

  // Wide enough for up to 16 cores; the arbiter uses only the low bits it needs.
  localparam int unsigned CORE_W = 4;

  typedef struct packed {
    req_class_t        cls;
    logic [CORE_W-1:0] core;
  } grant_t;

endpackage

// File: rtl/memory_arbiter_arb_rr_select.sv
// Combinational grant selection: dcache class over icache class, round-robin
// within a class starting at that class's pointer; force_i hands the grant to icaches.
module arb_rr_select
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS = 2,
  localparam int unsigned CW  = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] iren,
  input  logic [CPUS-1:0] dreq,
  input  logic [CW-1:0]   iptr,
  input  logic [CW-1:0]   dptr,
  input  logic            force_i,
  output grant_t          grant,
  output logic            valid
);

  logic          ihit, dhit;
  logic [CW-1:0] isel, dsel;
  int unsigned   iidx, didx;

  always_comb begin
    ihit = 1'b0;
    dhit = 1'b0;
    isel = '0;
    dsel = '0;
    iidx = 0;
    didx = 0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      iidx = (32'(iptr) + k) % CPUS;
      didx = (32'(dptr) + k) % CPUS;
      if (!ihit && iren[CW'(iidx)]) begin
        ihit = 1'b1;
        isel = CW'(iidx);
      end
      if (!dhit && dreq[CW'(didx)]) begin
        dhit = 1'b1;
        dsel = CW'(didx);
      end
    end
  end

  always_comb begin
    grant = '0;
    valid = 1'b0;
    if (force_i && ihit) begin
      grant.cls  = REQ_I;
      grant.core = CORE_W'(isel);
      valid      = 1'b1;
    end else if (dhit) begin
      grant.cls  = REQ_D;
      grant.core = CORE_W'(dsel);
      valid      = 1'b1;
    end else if (ihit) begin
      grant.cls  = REQ_I;
      grant.core = CORE_W'(isel);
      valid      = 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port among per-core icache/dcache requesters (IDLE/GRANT FSM).
// Optional icache anti-starvation counter enabled by MEMORY_ARBITER_FAIR_EN.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS       = 2,
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  ramstate_t            ramstate
);

  localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t    state, state_nxt;
  grant_t        gnt, sel;
  logic          sel_valid;
  logic [CW-1:0] iptr, dptr, gcore, nextp;
  logic          force_i;
  logic          active, done;

  assign gcore = gnt.core[CW-1:0];
  assign nextp = (gcore == CW'(CPUS-1)) ? '0 : gcore + CW'(1);

  arb_rr_select #(.CPUS(CPUS)) u_sel (
    .iren    (iREN),
    .dreq    (dREN | dWEN),
    .iptr    (iptr),
    .dptr    (dptr),
    .force_i (force_i),
    .grant   (sel),
    .valid   (sel_valid)
  );

`ifdef MEMORY_ARBITER_FAIR_EN
  localparam int unsigned FW = ($clog2(FAIR_LIMIT + 1) > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
  logic [FW-1:0] fcnt;

  // Counts dcache grants issued while some icache is left waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fcnt <= '0;
    end else if (!(|iREN)) begin
      fcnt <= '0;
    end else if (state == IDLE && sel_valid) begin
      if (sel.cls == REQ_I)
        fcnt <= '0;
      else if (fcnt != FW'(FAIR_LIMIT))
        fcnt <= fcnt + FW'(1);
    end
  end

  assign force_i = (fcnt == FW'(FAIR_LIMIT));
`else
  assign force_i = 1'b0 & (FAIR_LIMIT != 0);
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      gnt   <= '0;
      iptr  <= '0;
      dptr  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_valid)
        gnt <= sel;
      if (done) begin
        if (gnt.cls == REQ_D) dptr <= nextp;
        else                  iptr <= nextp;
      end
    end
  end

  // Strobes follow the live request so a withdrawn request stops driving RAM at once.
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    active   = 1'b0;
    done     = 1'b0;
    if (state == GRANT) begin
      if (gnt.cls == REQ_D) begin
        active   = dREN[gcore] | dWEN[gcore];
        ramREN   = dREN[gcore];
        ramWEN   = dWEN[gcore];
        ramaddr  = daddr[gcore];
        ramstore = dstore[gcore];
        if (active && ramstate == ACCESS) begin
          done         = 1'b1;
          dwait[gcore] = 1'b0;
          dload[gcore] = ramload;
        end
      end else begin
        active  = iREN[gcore];
        ramREN  = iREN[gcore];
        ramaddr = iaddr[gcore];
        if (active && ramstate == ACCESS) begin
          done         = 1'b1;
          iwait[gcore] = 1'b0;
          iload[gcore] = ramload;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_valid) state_nxt = GRANT;
      GRANT:   if (!active || done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
